ram_burst_ctrl: RTL

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

---
 rtl/ram_burst_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst controller for an asynchronous-style single-port RAM with a shared tri-state data bus.
// Accepts read/write burst commands, wraps addresses at DEPTH and inserts a turnaround cycle after reads.
module ram_burst_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH-1:0] req_len,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TURN  = 2'd3
    } state_t;

    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(1'b0);

    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
        if (a == LAST_ADDR) begin
            return ADDR_ZERO;
        end else begin
            return a + ADDR_ONE;
        end
    endfunction

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] beat_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic                  ram_cs_q;
    logic                  ram_we_q;
    logic                  ram_oe_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_last_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  err_q;
    logic                  drive_d;
    logic [ADDR_WIDTH-1:0] addr_inc_d;

    assign addr_inc_d = wrap_inc(addr_q);
    assign drive_d    = ram_cs_q & ram_we_q & ~ram_oe_q;
    assign ram_data   = drive_d ? wdata_q : {DATA_WIDTH{1'bz}};

    assign req_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WRITE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_data  = rsp_data_q;
    assign err       = err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_oe    = ram_oe_q;

    // Burst FSM with all RAM controls and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= ADDR_ZERO;
            addr_q      <= ADDR_ZERO;
            ram_addr_q  <= ADDR_ZERO;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            wdata_q     <= {DATA_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= {DATA_WIDTH{1'b0}};
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    ram_oe_q <= 1'b0;
                    if (req_valid) begin
                        if ({1'b0, req_addr} >= DEPTH_EXT) begin
                            err_q <= 1'b1;
                        end else if (req_we) begin
                            beat_q  <= req_len;
                            addr_q  <= req_addr;
                            state_q <= WRITE;
                        end else begin
                            beat_q     <= req_len;
                            addr_q     <= wrap_inc(req_addr);
                            ram_addr_q <= req_addr;
                            ram_cs_q   <= 1'b1;
                            ram_oe_q   <= 1'b1;
                            state_q    <= READ;
                        end
                    end
                end
                WRITE: begin
                    ram_oe_q <= 1'b0;
                    if (wr_valid) begin
                        ram_cs_q   <= 1'b1;
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= addr_q;
                        wdata_q    <= wr_data;
                        addr_q     <= addr_inc_d;
                        if (beat_q == ADDR_ZERO) begin
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_q - ADDR_ONE;
                        end
                    end else begin
                        ram_cs_q <= 1'b0;
                        ram_we_q <= 1'b0;
                    end
                end
                READ: begin
                    // The beat whose controls were active this cycle is captured now.
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= ram_data;
                    ram_we_q    <= 1'b0;
                    if (beat_q == ADDR_ZERO) begin
                        rsp_last_q <= 1'b1;
                        ram_cs_q   <= 1'b0;
                        ram_oe_q   <= 1'b0;
                        state_q    <= TURN;
                    end else begin
                        ram_addr_q <= addr_q;
                        addr_q     <= addr_inc_d;
                        beat_q     <= beat_q - ADDR_ONE;
                    end
                end
                TURN: begin
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    ram_oe_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    ram_oe_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule
